mac_seq_ctrl: RTL and testbench

MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

---
 rtl/mac_pkg.sv | 27 ++
 rtl/mac_seq_timer.sv | 27 ++
 rtl/mac_seq_ctrl.sv | 171 +++++++++++++++++
 tb/tb_mac_seq_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared types and encodings for the MAC array sequencer.
package mac_pkg;

  localparam int COL_DEFAULT = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_EXEC  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Phase timer must hold the longest of: load length, max query count, drain length.
  function automatic int timer_width(input int col, input int aw, input int drain);
    int m;
    m = col + 1;
    if ((1 << aw) - 1 > m) m = (1 << aw) - 1;
    if (drain > m) m = drain;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/mac_seq_timer.sv
// Loadable down-counter with stall-gated enable and a zero flag.
module mac_seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for the chained MAC array: load keys, execute queries, drain, done.
// Optional MAC_SEQ_PERF_EN adds a 16-bit stall_cnt output.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int COL       = COL_DEFAULT,
  parameter int AW        = 6,
  parameter int DRAIN_CYC = COL + 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] n_q,
  input  logic          cfg_signed,
  input  logic          cfg_reconf,
  input  logic          ofifo_afull,
  output logic [1:0]    inst,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic          is_signed,
  output logic          reconfigure,
  output logic          busy,
  output logic          done
`ifdef MAC_SEQ_PERF_EN
  ,
  output logic [15:0]   stall_cnt
`endif
);

  localparam int TW = timer_width(COL, AW, DRAIN_CYC);

  state_t        state, state_nxt;
  logic [AW-1:0] nq_lat;
  logic [AW-1:0] addr;
  logic          active;
  logic          beat;
  logic          accept;
  logic          tmr_load;
  logic          tmr_en;
  logic          tmr_zero;
  logic [TW-1:0] tmr_val;

  assign active = (state == ST_LOAD) || (state == ST_EXEC);
  assign beat   = active && !ofifo_afull;
  assign accept = (state == ST_IDLE) && start;

  mac_seq_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Timer holds (beats remaining - 1); a phase ends on the beat that sees zero.
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    tmr_val   = '0;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_LOAD;
          tmr_load  = 1'b1;
          tmr_val   = TW'(COL + 1);
        end
      end
      ST_LOAD: begin
        if (beat) begin
          if (tmr_zero) begin
            tmr_load = 1'b1;
            if (nq_lat == '0) begin
              state_nxt = ST_DRAIN;
              tmr_val   = TW'(DRAIN_CYC - 1);
            end else begin
              state_nxt = ST_EXEC;
              tmr_val   = TW'(nq_lat) - TW'(1);
            end
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (beat) begin
          if (tmr_zero) begin
            state_nxt = ST_DRAIN;
            tmr_load  = 1'b1;
            tmr_val   = TW'(DRAIN_CYC - 1);
          end else begin
            tmr_en = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (tmr_zero) begin
          state_nxt = ST_DONE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    inst   = INST_IDLE;
    mem_rd = 1'b0;
    busy   = (state != ST_IDLE);
    done   = (state == ST_DONE);
    if (beat) begin
      mem_rd = 1'b1;
      inst   = (state == ST_LOAD) ? INST_LOAD : INST_EXEC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nq_lat      <= '0;
      is_signed   <= 1'b0;
      reconfigure <= 1'b0;
    end else if (accept) begin
      nq_lat      <= n_q;
      is_signed   <= cfg_signed;
      reconfigure <= cfg_reconf;
    end
  end

  // Address runs continuously across LOAD into EXEC and sticks at the top rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (state == ST_IDLE) begin
      addr <= '0;
    end else if (beat && (addr != '1)) begin
      addr <= addr + AW'(1);
    end
  end

  assign mem_addr = addr;

`ifdef MAC_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (accept) begin
      stall_cnt <= '0;
    end else if (active && ofifo_afull && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed bench for mac_seq_ctrl: job table plus reset-abort sequence.
module tb_mac_seq_ctrl;

  localparam int COL  = 8;
  localparam int AW   = 6;
  localparam int AMAX = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] n_q;
  logic          cfg_signed;
  logic          cfg_reconf;
  logic          ofifo_afull;
  logic [1:0]    inst;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic          is_signed;
  logic          reconfigure;
  logic          busy;
  logic          done;
`ifdef MAC_SEQ_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mac_seq_ctrl #(
    .COL(COL),
    .AW (AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .n_q         (n_q),
    .cfg_signed  (cfg_signed),
    .cfg_reconf  (cfg_reconf),
    .ofifo_afull (ofifo_afull),
    .inst        (inst),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .is_signed   (is_signed),
    .reconfigure (reconfigure),
    .busy        (busy),
    .done        (done)
`ifdef MAC_SEQ_PERF_EN
    ,
    .stall_cnt   (stall_cnt)
`endif
  );

  // exp_lat = cycle index of done, start cycle being 0 (so 27 cycles inclusive for n_q=4).
  typedef struct {
    int nq;
    bit sgn;
    bit rcf;
    int st_from;
    int st_len;
    int pulse_k;
    int exp_lat;
    int exp_stall;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_job(input int idx, input vec_t v);
    int  beats;
    int  exp_addr;
    int  total;
    bit  got_done;
    beats    = 0;
    exp_addr = 0;
    total    = COL + 2 + v.nq;
    got_done = 1'b0;
    @(negedge clk);
    start       = 1'b1;
    n_q         = AW'(v.nq);
    cfg_signed  = v.sgn;
    cfg_reconf  = v.rcf;
    ofifo_afull = 1'b0;
    #1;
    chk($sformatf("job%0d idle_busy", idx), busy, 0);
    for (int k = 1; k <= 200 && !got_done; k++) begin
      @(negedge clk);
      start = (k == v.pulse_k);
      if (k == v.pulse_k) begin
        cfg_signed = !v.sgn;
        cfg_reconf = !v.rcf;
        n_q        = AW'(7);
      end
      ofifo_afull = (k >= v.st_from) && (k < v.st_from + v.st_len);
      #1;
      if (done) begin
        got_done = 1'b1;
        chk($sformatf("job%0d latency", idx), k, v.exp_lat);
        chk($sformatf("job%0d beats", idx), beats, total);
        chk($sformatf("job%0d done_inst", idx), inst, 0);
`ifdef MAC_SEQ_PERF_EN
        chk($sformatf("job%0d stall_cnt_done", idx), stall_cnt, v.exp_stall);
`endif
      end else begin
        chk($sformatf("job%0d k%0d busy", idx, k), busy, 1);
        if (beats < total) begin
          if (ofifo_afull) begin
            chk($sformatf("job%0d k%0d stall_inst", idx, k), inst, 0);
            chk($sformatf("job%0d k%0d stall_rd", idx, k), mem_rd, 0);
          end else begin
            chk($sformatf("job%0d k%0d inst", idx, k), inst, (beats < COL + 2) ? 1 : 2);
            chk($sformatf("job%0d k%0d rd", idx, k), mem_rd, 1);
            chk($sformatf("job%0d k%0d addr", idx, k), mem_addr, exp_addr);
            beats++;
            if (exp_addr < AMAX) exp_addr++;
          end
        end else begin
          chk($sformatf("job%0d k%0d drain_inst", idx, k), inst, 0);
          chk($sformatf("job%0d k%0d drain_rd", idx, k), mem_rd, 0);
        end
      end
      chk($sformatf("job%0d k%0d is_signed", idx, k), is_signed, v.sgn);
      chk($sformatf("job%0d k%0d reconfigure", idx, k), reconfigure, v.rcf);
`ifdef MAC_SEQ_PERF_EN
      if (k == 1) chk($sformatf("job%0d stall_cnt_clr", idx), stall_cnt, 0);
`endif
    end
    if (!got_done) chk($sformatf("job%0d timeout", idx), 0, 1);
    @(negedge clk);
    start       = 1'b0;
    ofifo_afull = 1'b0;
    #1;
    chk($sformatf("job%0d post_busy", idx), busy, 0);
    chk($sformatf("job%0d post_done", idx), done, 0);
    chk($sformatf("job%0d post_signed", idx), is_signed, v.sgn);
    chk($sformatf("job%0d post_reconf", idx), reconfigure, v.rcf);
`ifdef MAC_SEQ_PERF_EN
    chk($sformatf("job%0d stall_cnt_hold", idx), stall_cnt, v.exp_stall);
`endif
  endtask

  initial begin
    int ndone;
    //            nq sgn rcf from len pulse lat stall
    vecs[0] = '{  4, 1, 0,  0, 0,  0, 26, 0};
    vecs[1] = '{  4, 0, 1, 12, 3,  0, 29, 3};
    vecs[2] = '{  0, 1, 1,  0, 0,  0, 22, 0};
    vecs[3] = '{  1, 0, 0,  3, 2,  0, 25, 2};
    vecs[4] = '{  2, 1, 0, 15, 3,  0, 24, 0};
    vecs[5] = '{  4, 1, 1,  0, 0, 12, 26, 0};
    vecs[6] = '{  3, 0, 1,  0, 0, 25, 25, 0};
    vecs[7] = '{  4, 0, 0,  9, 5,  0, 31, 5};
    vecs[8] = '{ 60, 1, 0,  0, 0,  0, 82, 0};

    reset       = 1'b1;
    start       = 1'b0;
    n_q         = '0;
    cfg_signed  = 1'b1;
    cfg_reconf  = 1'b1;
    ofifo_afull = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst inst", inst, 0);
    chk("rst mem_rd", mem_rd, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst is_signed", is_signed, 0);
    chk("rst reconfigure", reconfigure, 0);
    reset       = 1'b0;
    ofifo_afull = 1'b0;

    for (int i = 0; i < 9; i++) run_job(i, vecs[i]);

    // Abort a job with reset on the second EXEC beat; no done may follow.
    @(negedge clk);
    start      = 1'b1;
    n_q        = AW'(4);
    cfg_signed = 1'b1;
    cfg_reconf = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    chk("abort pre_inst", inst, 2);
    chk("abort pre_addr", mem_addr, COL + 3);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("abort inst", inst, 0);
    chk("abort mem_rd", mem_rd, 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort is_signed", is_signed, 0);
    chk("abort reconfigure", reconfigure, 0);
`ifdef MAC_SEQ_PERF_EN
    chk("abort stall_cnt", stall_cnt, 0);
`endif
    reset = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (done) ndone++;
    end
    chk("abort no_done", ndone, 0);
    run_job(99, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
